mem_access_stage: RTL and testbench

- Memory stage of the 16-bit pipelined core; sits between the execute/memory pipeline register and the memory/write-back register.
- Converts load/store requests into a handshaked, variable-latency data-memory transaction.
- Stalls the pipeline until the transaction completes, then presents load data for the memory/write-back register to capture.
- Detects illegal accesses and memory timeouts, and raises a sticky error.

---
 rtl/mem_access_stage_pkg.sv | 14 +
 rtl/mem_access_stage_if.sv | 26 ++
 rtl/mem_wait_timer.sv | 28 ++
 rtl/mem_access_stage.sv | 129 ++++++++++++
 tb/tb_mem_access_stage.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared types for the memory-access stage: FSM state encoding and the
// default datapath width used by the stage, its interface and its timer.
package mem_stage_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } state_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus.
// master (stage): drives dmem_req/we/addr/wdata; samples ready/rvalid/rdata.
// slave (memory): the reverse.
interface mem_access_stage_if
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ready;
    logic              dmem_rvalid;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Transaction wait counter: clr_i zeroes it, en_i advances it; it saturates
// at MAX_WAIT-1 where tc_o is raised.
// Ports: clk, rst (sync, active-high), clr_i, en_i, tc_o.
module mem_wait_timer #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

    logic [CW-1:0] cnt_q;

    assign tc_o = (cnt_q == CW'(MAX_WAIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !tc_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: turns load/store requests into a handshaked dmem
// transaction, stalls until done, flags illegal accesses and timeouts.
// Ports: clk, rst (sync, active-high); mem_read/mem_write/addr/wdata from
// EX/MEM; bus (dmem master); mem_data, stall, mem_err to MEM/WB.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [DATA_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    mem_access_stage_if.master  bus,
    output logic [DATA_W-1:0]   mem_data,
    output logic                stall,
    output logic                mem_err
);
    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              tmr_clr, tmr_en, tmo;
    logic              access, legal;

    assign access = mem_read | mem_write;
    // Exactly one request kind, halfword aligned.
    assign legal  = (mem_read ^ mem_write) & ~addr[0];
    assign stall  = access & (state_q != DONE);

    assign bus.dmem_req   = req_q;
    assign bus.dmem_we    = we_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_wdata = wdata_q;
    assign mem_data       = data_q;
    assign mem_err        = err_q;

    mem_wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr_i(tmr_clr),
        .en_i (tmr_en),
        .tc_o (tmo)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        err_d   = err_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    if (legal) begin
                        addr_d  = addr;
                        wdata_d = wdata;
                        we_d    = mem_write;
                        req_d   = 1'b1;
                        tmr_clr = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            ISSUE: begin
                tmr_en = 1'b1;
                // Handshake completion wins over a same-cycle timeout.
                if (bus.dmem_ready) begin
                    req_d   = 1'b0;
                    state_d = we_q ? DONE : WAIT_RESP;
                end else if (tmo) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    data_d  = '0;
                    state_d = DONE;
                end
            end
            WAIT_RESP: begin
                tmr_en = 1'b1;
                if (bus.dmem_rvalid) begin
                    data_d  = bus.dmem_rdata;
                    state_d = DONE;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    data_d  = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed accesses with a scoreboard checked
// whenever the stage releases the pipeline on an active access.
module tb_mem_access_stage;

    localparam int DW = 16;
    localparam int MW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read, mem_write;
    logic [DW-1:0] addr, wdata, mem_data;
    logic          stall, mem_err;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] model_data;
    logic          model_err;

    always #5 clk = ~clk;

    mem_access_stage_if #(.DATA_W(DW)) bus ();

    mem_access_stage #(
        .DATA_W  (DW),
        .MAX_WAIT(MW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .addr     (addr),
        .wdata    (wdata),
        .bus      (bus),
        .mem_data (mem_data),
        .stall    (stall),
        .mem_err  (mem_err)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: MEM/WB captures when access is high and stall low.
    always @(negedge clk) begin
        if (!rst && (mem_read || mem_write) && !stall) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: output seen, no expected entry");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mem_data", 32'(mem_data), 32'(e.data));
                chk("mem_err", 32'(mem_err), 32'(e.err));
            end
        end
    end

    // k=0 is the IDLE cycle; ready at k=1+rdy; rvalid at k=2+rdy+rv (rv<0: never).
    task automatic do_access(input logic rd, input logic wr,
                             input logic [DW-1:0] a, input logic [DW-1:0] wd,
                             input int rdy, input int rv,
                             input logic [DW-1:0] rdat, input bit legal,
                             input bit tmo, input int exp_stall,
                             input bit keep);
        int  k;
        bit  done;
        bit  exp_req;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        if (!legal) begin
            model_err = 1'b1;
        end else if (tmo) begin
            model_err  = 1'b1;
            model_data = '0;
        end else if (rd) begin
            model_data = rdat;
        end
        sb.push_back('{data: model_data, err: model_err});
        k    = 0;
        done = 1'b0;
        while (!done && k < 40) begin
            bus.dmem_ready  = (k == 1 + rdy);
            bus.dmem_rvalid = (rv >= 0) && (k == 2 + rdy + rv);
            bus.dmem_rdata  = bus.dmem_rvalid ? rdat : 16'h5A5A;
            @(negedge clk);
            exp_req = legal && k >= 1 && k <= 1 + rdy;
            chk("dmem_req", 32'(bus.dmem_req), 32'(exp_req));
            if (exp_req) begin
                chk("dmem_addr", 32'(bus.dmem_addr), 32'(a));
                chk("dmem_wdata", 32'(bus.dmem_wdata), 32'(wd));
                chk("dmem_we", 32'(bus.dmem_we), 32'(wr));
            end
            if (!stall) begin
                done = 1'b1;
            end else begin
                k++;
                step();
            end
        end
        chk("stall_cycles", 32'(k), 32'(exp_stall));
        step();
        bus.dmem_ready  = 1'b0;
        bus.dmem_rvalid = 1'b0;
        if (!keep) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        step();
        rst        = 1'b0;
        model_data = '0;
        model_err  = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        addr            = '0;
        wdata           = '0;
        bus.dmem_ready  = 1'b0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = '0;
        model_data      = '0;
        model_err       = 1'b0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_we", 32'(bus.dmem_we), 32'd0);
        chk("rst_addr", 32'(bus.dmem_addr), 32'd0);
        chk("rst_wdata", 32'(bus.dmem_wdata), 32'd0);
        chk("rst_mem_data", 32'(mem_data), 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        step();

        // rd wr addr wdata rdy rv rdata legal tmo stall keep
        do_access(1, 0, 16'h0010, 16'h0000, 0, 0, 16'hBEEF, 1, 0, 3, 0);
        do_access(0, 1, 16'h0020, 16'h1234, 3, -1, 16'h0000, 1, 0, 5, 0);
        do_access(1, 0, 16'h0030, 16'h9999, 1, 2, 16'hC0DE, 1, 0, 6, 0);
        do_access(1, 0, 16'h0040, 16'h0000, 0, 0, 16'h1111, 1, 0, 3, 1);
        do_access(1, 0, 16'h0042, 16'h0000, 0, 1, 16'h2222, 1, 0, 4, 0);
        @(negedge clk);
        chk("hold_mem_data", 32'(mem_data), 32'h2222);
        step();

        do_access(1, 0, 16'h0011, 16'h0000, 5, 0, 16'hFFFF, 0, 0, 1, 0);
        do_access(1, 1, 16'h0050, 16'h0000, 5, 0, 16'hFFFF, 0, 0, 1, 0);
        step();
        @(negedge clk);
        chk("err_sticky", 32'(mem_err), 32'd1);
        chk("err_no_req", 32'(bus.dmem_req), 32'd0);
        step();

        do_reset();
        @(negedge clk);
        chk("rst2_mem_err", 32'(mem_err), 32'd0);
        chk("rst2_mem_data", 32'(mem_data), 32'd0);
        step();
        do_access(1, 0, 16'h0070, 16'h0000, 0, 0, 16'h7777, 1, 0, 3, 0);
        do_access(1, 0, 16'h0060, 16'h0000, 0, -1, 16'h0000, 1, 1, MW + 1, 0);
        step();
        step();
        @(negedge clk);
        chk("tmo_err_sticky", 32'(mem_err), 32'd1);
        chk("tmo_mem_data", 32'(mem_data), 32'd0);
        step();

        do_reset();
        do_access(1, 0, 16'h0072, 16'h0000, 0, 0, 16'h3333, 1, 0, 3, 0);
        mem_read = 1'b1;
        addr     = 16'h0080;
        step();
        bus.dmem_ready = 1'b1;
        step();
        bus.dmem_ready = 1'b0;
        @(negedge clk);
        chk("mid_req_low", 32'(bus.dmem_req), 32'd0);
        chk("mid_stall", 32'(stall), 32'd1);
        step();
        rst      = 1'b1;
        mem_read = 1'b0;
        step();
        rst             = 1'b0;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 16'hDEAD;
        @(negedge clk);
        chk("abort_req", 32'(bus.dmem_req), 32'd0);
        chk("abort_we", 32'(bus.dmem_we), 32'd0);
        chk("abort_addr", 32'(bus.dmem_addr), 32'd0);
        chk("abort_wdata", 32'(bus.dmem_wdata), 32'd0);
        chk("abort_mem_err", 32'(mem_err), 32'd0);
        chk("abort_stall", 32'(stall), 32'd0);
        step();
        bus.dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("late_rvalid_data", 32'(mem_data), 32'd0);
        chk("late_rvalid_req", 32'(bus.dmem_req), 32'd0);
        step();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
